div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Iterative radix-2 integer divider for the scalar core's M-extension (DIV/DIVU/REM/REMU).
//  Counterpart of the ALU's single-cycle combinational multiply path: multi-cycle, decoupled by
//  valid/ready handshakes on both sides. Sits beside the ALU in EX; the EX stage stalls while busy.
// PARAMETERS
//  DWidth   32  operand/result width; iteration count = DWidth
//  OpWidth  5   width of op_sel_i; encodings DIV/DIVU/REM/REMU from pkg_opfunct3
// PORTS
//  clk_i      in   1        single clock, rising edge
//  rst_ni     in   1        asynchronous reset, active-low
//  valid_i    in   1        request valid
//  ready_o    out  1        unit can accept a request (high only in IDLE)
//  a_i        in   DWidth   dividend
//  b_i        in   DWidth   divisor
//  op_sel_i   in   OpWidth  DIV, DIVU, REM or REMU
//  kill_i     in   1        synchronous abort of in-flight op (pipeline flush)
//  valid_o    out  1        result valid
//  ready_i    in   1        consumer accepts result
//  res_o      out  DWidth   quotient (DIV/DIVU) or remainder (REM/REMU)
//  zero_o     out  1        ~|res_o
// BEHAVIOUR
//  Reset (async, rst_ni=0): state=IDLE, ready_o=1, valid_o=0, res_o=0, zero_o=1, counter=0.
//  FSM: IDLE -> CALC -> DONE -> IDLE.
//   IDLE: accept on valid_i&&ready_o; latch a_i,b_i,op_sel_i; inputs ignored afterwards.
//         Special case at accept -> DONE next cycle (latency 1):
//          b=0: quotient=all ones, remainder=a.
//          signed (DIV/REM) a=MIN_INT, b=-1: quotient=MIN_INT, remainder=0.
//          op_sel not DIV/DIVU/REM/REMU: res_o=0.
//         Else -> CALC with |a|,|b| (signed ops) or raw a,b (unsigned), counter=0.
//   CALC: one restoring step per cycle: {rem,quo} shifted left 1; if rem>=divisor then subtract
//         and set quotient LSB. After DWidth steps -> DONE.
//   DONE: valid_o=1, res_o stable; sign fixup applied when entering DONE:
//         quotient negated iff signed op and sign(a)!=sign(b); remainder takes sign(a).
//         Leave to IDLE on valid_o&&ready_i; ready_o=1 the following cycle (no same-cycle re-accept).
//  Latency (normal op): accept edge T, valid_o high from edge T+DWidth+1.
//  Back-pressure: ready_i=0 holds DONE, valid_o and res_o indefinitely.
//  kill_i: in any state -> IDLE next edge, valid_o=0, result discarded; in IDLE with valid_i
//   it wins (no accept). Deassertion of valid_i after accept has no effect.
//  Widths: internal remainder DWidth+1 bits (compare by subtraction carry); counter $clog2(DWidth)+1.
//   Absolute value of MIN_INT = 2^(DWidth-1), representable unsigned; no overflow in CALC.
//  Reset mid-operation: immediate return to reset values; no partial result emitted.
// STRUCTURE
//  pkg_opfunct3: add DIV, DIVU, REM, REMU op codes (distinct from existing ALU codes) and
//   div_state_e {IDLE, CALC, DONE}.
//  One sub-module: div_step (combinational restoring iteration: rem_i,quo_i,divisor_i ->
//   rem_o,quo_o). FSM, counter, sign fixup and handshakes live in div_unit.
// TESTING
//  1 DIVU 100/7, ready_i=1 -> res_o=14 (0x0000000E), valid_o at T+33, one cycle wide.
//  2 REM -7 % 2 and DIV -7/2 -> 0xFFFFFFFF (-1) and 0xFFFFFFFD (-3); REMU 0xFFFFFFF9 % 2 -> 1.
//  3 DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000,
//    REM same -> 0; all valid_o at T+1; zero_o=1 on the REM overflow case.
//  4 Hold ready_i=0 5 cycles in DONE -> valid_o, res_o stable; ready_o=0; new valid_i ignored.
//  5 rst_ni=0 at CALC cycle 10 -> outputs at reset values immediately; next request correct.
//  6 kill_i at CALC cycle 20 -> IDLE next edge, no valid_o; back-to-back request right after ok.
//  Plus random signed/unsigned sweep vs. reference model incl. MIN_INT, 0, +/-1 operands.

Source files
------------

// File: rtl/pkg_opfunct3.sv
// rtl/pkg_opfunct3.sv - shared EX-stage op codes and divider state encoding
package pkg_opfunct3;

    localparam int OpCodeW = 5;

    typedef enum logic [OpCodeW-1:0] {
        OP_ADD  = 5'h00,
        OP_SUB  = 5'h01,
        OP_AND  = 5'h02,
        OP_OR   = 5'h03,
        OP_XOR  = 5'h04,
        OP_SLL  = 5'h05,
        OP_SRL  = 5'h06,
        OP_SRA  = 5'h07,
        OP_SLT  = 5'h08,
        OP_SLTU = 5'h09,
        OP_MUL  = 5'h0A,
        OP_DIV  = 5'h10,
        OP_DIVU = 5'h11,
        OP_REM  = 5'h12,
        OP_REMU = 5'h13
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic logic is_signed_div(input logic [OpCodeW-1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_rem_op(input logic [OpCodeW-1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic is_div_family(input logic [OpCodeW-1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// rtl/div_unit_step.sv - one combinational restoring-division iteration
module div_step #(
    parameter int DWidth = 32
) (
    input  logic [DWidth:0]   rem_i,
    input  logic [DWidth-1:0] quo_i,
    input  logic [DWidth-1:0] divisor_i,
    output logic [DWidth:0]   rem_o,
    output logic [DWidth-1:0] quo_o
);

    logic [DWidth:0]   rem_sh;
    logic [DWidth+1:0] diff;
    logic              borrow;
    logic              unused_rem_msb;

    // rem_i stays below the divisor, so its top bit is always zero and drops out of the shift
    assign rem_sh         = {rem_i[DWidth-1:0], quo_i[DWidth-1]};
    assign diff           = {1'b0, rem_sh} - {2'b00, divisor_i};
    assign borrow         = diff[DWidth+1];
    assign unused_rem_msb = rem_i[DWidth];

    assign rem_o = borrow ? rem_sh : diff[DWidth:0];
    assign quo_o = {quo_i[DWidth-2:0], ~borrow};

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 DIV/DIVU/REM/REMU unit with valid/ready on both sides
module div_unit
    import pkg_opfunct3::*;
#(
    parameter int DWidth  = 32,
    parameter int OpWidth = 5
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [DWidth-1:0]  a_i,
    input  logic [DWidth-1:0]  b_i,
    input  logic [OpWidth-1:0] op_sel_i,
    input  logic               kill_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [DWidth-1:0]  res_o,
    output logic               zero_o
);

    localparam int CntW = $clog2(DWidth) + 1;
    localparam logic [CntW-1:0]   LastCnt = CntW'(DWidth);
    localparam logic [DWidth-1:0] MinInt  = {1'b1, {(DWidth-1){1'b0}}};

    div_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DWidth:0]   rem_q, rem_d;
    logic [DWidth-1:0] quo_q, quo_d;
    logic [DWidth-1:0] dvs_q, dvs_d;
    logic [DWidth-1:0] res_q, res_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic              sel_rem_q, sel_rem_d;

    logic [DWidth:0]   step_rem;
    logic [DWidth-1:0] step_quo;
    logic [DWidth-1:0] fixed_res;
    logic              op_signed, op_rem, op_valid, a_neg, b_neg, accept;
    logic              unused_rem_top;

    assign op_signed      = is_signed_div(OpCodeW'(op_sel_i));
    assign op_rem         = is_rem_op(OpCodeW'(op_sel_i));
    assign op_valid       = is_div_family(OpCodeW'(op_sel_i));
    assign a_neg          = op_signed & a_i[DWidth-1];
    assign b_neg          = op_signed & b_i[DWidth-1];
    assign accept         = (state_q == IDLE) && valid_i && !kill_i;
    assign unused_rem_top = rem_q[DWidth];

    div_step #(.DWidth(DWidth)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (kill_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (valid_i)          state_d = CALC;
                CALC:    if (cnt_q == LastCnt) state_d = DONE;
                DONE:    if (ready_i)          state_d = IDLE;
                default:                       state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ready_o = (state_q == IDLE);
        valid_o = (state_q == DONE);
    end

    always_comb begin
        if (sel_rem_q) begin
            fixed_res = neg_rem_q ? -rem_q[DWidth-1:0] : rem_q[DWidth-1:0];
        end else begin
            fixed_res = neg_quo_q ? -quo_q : quo_q;
        end
    end

    // Special cases skip the iterations by preloading a finished quotient/remainder
    // and parking the counter at its terminal value, so DONE follows one edge later.
    always_comb begin
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        res_d     = res_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        sel_rem_d = sel_rem_q;
        if (accept) begin
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = a_neg ? -a_i : a_i;
            dvs_d     = b_neg ? -b_i : b_i;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            sel_rem_d = op_rem;
            if (!op_valid) begin
                cnt_d     = LastCnt;
                quo_d     = '0;
                neg_quo_d = 1'b0;
                neg_rem_d = 1'b0;
                sel_rem_d = 1'b0;
            end else if (b_i == '0) begin
                cnt_d     = LastCnt;
                quo_d     = '1;
                rem_d     = {1'b0, a_i};
                neg_quo_d = 1'b0;
                neg_rem_d = 1'b0;
            end else if (op_signed && (a_i == MinInt) && (b_i == '1)) begin
                cnt_d     = LastCnt;
                quo_d     = MinInt;
                neg_quo_d = 1'b0;
                neg_rem_d = 1'b0;
            end
        end else if ((state_q == CALC) && !kill_i) begin
            if (cnt_q != LastCnt) begin
                cnt_d = cnt_q + CntW'(1);
                rem_d = step_rem;
                quo_d = step_quo;
            end else begin
                res_d = fixed_res;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            res_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            sel_rem_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            res_q     <= res_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            sel_rem_q <= sel_rem_d;
        end
    end

    assign res_o  = res_q;
    assign zero_o = ~|res_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed and random scoreboard bench for div_unit
module tb_div_unit;
    import pkg_opfunct3::*;

    localparam logic [31:0] MIN_I = 32'h8000_0000;
    localparam logic [31:0] MAX_I = 32'h7FFF_FFFF;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        kill_i = 1'b0;
    logic        ready_i = 1'b1;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic [4:0]  op_sel_i = '0;
    logic        ready_o, valid_o, zero_o;
    logic [31:0] res_o;

    div_unit #(.DWidth(32), .OpWidth(5)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .a_i      (a_i),
        .b_i      (b_i),
        .op_sel_i (op_sel_i),
        .kill_i   (kill_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .res_o    (res_o),
        .zero_o   (zero_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   t_acc   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic ovf;
        ovf = (a == MIN_I) && (b == 32'hFFFF_FFFF);
        case (op)
            OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REMU: return (b == 0) ? a : a % b;
            OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? MIN_I : 32'($signed(a) / $signed(b));
            OP_REM:  return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic sgn;
        sgn = (op == OP_DIV) || (op == OP_REM);
        if (!((op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU))) return 1;
        if (b == 0) return 1;
        if (sgn && a == MIN_I && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
        exp_t e;
        int   k;
        k = 0;
        @(negedge clk_i);
        while (!ready_o && k < 100) begin
            @(negedge clk_i);
            k++;
        end
        if (!ready_o) check({tag, " ready timeout"}, 32'(ready_o), 32'h1);
        op_sel_i = op;
        a_i      = a;
        b_i      = b;
        valid_i  = 1'b1;
        e.res    = ref_res(op, a, b);
        e.lat    = ref_lat(op, a, b);
        e.tag    = tag;
        sb.push_back(e);
        @(posedge clk_i);
        @(negedge clk_i);
        t_acc   = cyc;
        valid_i = 1'b0;
        a_i     = $urandom;
        b_i     = $urandom;
    endtask

    task automatic expect_result(output logic [31:0] exp_res);
        exp_t e;
        int   k;
        exp_res = '0;
        if (sb.size() == 0) begin
            check("scoreboard empty", 32'h0, 32'h1);
            return;
        end
        e       = sb.pop_front();
        exp_res = e.res;
        k       = 0;
        while (!valid_o && k < 100) begin
            @(negedge clk_i);
            k++;
        end
        check({e.tag, " valid"}, 32'(valid_o), 32'h1);
        check({e.tag, " latency"}, 32'(cyc - t_acc), 32'(e.lat));
        check({e.tag, " res"}, res_o, e.res);
        check({e.tag, " zero"}, 32'(zero_o), 32'(e.res == 0));
    endtask

    task automatic after_handshake(input string tag);
        @(negedge clk_i);
        check({tag, " valid_o drop"}, 32'(valid_o), 32'h0);
        check({tag, " ready_o back"}, 32'(ready_o), 32'h1);
    endtask

    logic [31:0] er;

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return MIN_I;
            4:       return MAX_I;
            5:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        // reset values
        repeat (2) @(negedge clk_i);
        check("rst ready_o", 32'(ready_o), 32'h1);
        check("rst valid_o", 32'(valid_o), 32'h0);
        check("rst res_o", res_o, 32'h0);
        check("rst zero_o", 32'(zero_o), 32'h1);
        rst_ni = 1'b1;

        send(OP_DIVU, 32'd100, 32'd7, "divu 100/7");
        expect_result(er);
        after_handshake("divu 100/7");

        send(OP_REM, 32'hFFFF_FFF9, 32'd2, "rem -7%2");
        expect_result(er);
        send(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div -7/2");
        expect_result(er);
        send(OP_REMU, 32'hFFFF_FFF9, 32'd2, "remu");
        expect_result(er);

        send(OP_DIV, 32'd5, 32'd0, "div 5/0");
        expect_result(er);
        send(OP_REM, 32'd5, 32'd0, "rem 5/0");
        expect_result(er);
        send(OP_DIV, MIN_I, 32'hFFFF_FFFF, "div ovf");
        expect_result(er);
        send(OP_REM, MIN_I, 32'hFFFF_FFFF, "rem ovf");
        expect_result(er);
        send(OP_ADD, 32'd5, 32'd3, "non-div op");
        expect_result(er);
        after_handshake("non-div op");

        // back-pressure with a competing request on the inputs
        ready_i = 1'b0;
        send(OP_DIV, 32'd1000, 32'hFFFF_FFF6, "bp div");
        expect_result(er);
        valid_i  = 1'b1;
        op_sel_i = OP_DIVU;
        a_i      = 32'd77;
        b_i      = 32'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("bp valid_o hold", 32'(valid_o), 32'h1);
            check("bp res_o hold", res_o, er);
            check("bp ready_o low", 32'(ready_o), 32'h0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        after_handshake("bp");
        @(negedge clk_i);
        check("bp stray not accepted", 32'(ready_o), 32'h1);

        // asynchronous reset mid-calculation
        send(OP_DIVU, 32'd123456, 32'd789, "rst mid");
        repeat (10) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("mid rst ready_o", 32'(ready_o), 32'h1);
        check("mid rst valid_o", 32'(valid_o), 32'h0);
        check("mid rst res_o", res_o, 32'h0);
        check("mid rst zero_o", 32'(zero_o), 32'h1);
        void'(sb.pop_back());
        @(negedge clk_i);
        rst_ni = 1'b1;
        send(OP_DIVU, 32'd123456, 32'd789, "post rst");
        expect_result(er);

        // kill mid-calculation, then an immediate follow-on request
        send(OP_DIV, 32'hFFFF_FC18, 32'd7, "killed");
        repeat (20) @(negedge clk_i);
        kill_i = 1'b1;
        @(negedge clk_i);
        kill_i = 1'b0;
        check("kill valid_o", 32'(valid_o), 32'h0);
        check("kill ready_o", 32'(ready_o), 32'h1);
        void'(sb.pop_back());
        send(OP_REMU, 32'd1000, 32'd7, "after kill");
        expect_result(er);

        // kill beats a request presented in IDLE
        @(negedge clk_i);
        op_sel_i = OP_DIV;
        a_i      = 32'd9;
        b_i      = 32'd0;
        valid_i  = 1'b1;
        kill_i   = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0;
        kill_i  = 1'b0;
        check("kill+valid no accept", 32'(ready_o), 32'h1);
        @(negedge clk_i);
        check("kill+valid no result", 32'(valid_o), 32'h0);

        for (int i = 0; i < 40; i++) begin
            logic [4:0] op;
            case ($urandom_range(0, 3))
                0:       op = OP_DIV;
                1:       op = OP_DIVU;
                2:       op = OP_REM;
                default: op = OP_REMU;
            endcase
            send(op, pick(), pick(), $sformatf("rand%0d", i));
            expect_result(er);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
